// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// iterative RV32M multiply/divide unit.
//
// Signals:
//   start  - launch an operation (sampled when the unit is not calculating)
//   flush  - synchronous abort from branch mispredict / trap
//   op     - func3 of the M-extension instruction
//   rs1    - operand A (multiplicand / dividend)
//   rs2    - operand B (multiplier / divisor)
//   busy   - unit is iterating; the hazard unit stalls on this
//   done   - one-cycle pulse, result is valid
//   result - registered result, holds until the next completion
//
// Modports:
//   master - the pipeline side driving requests
//   slave  - the multiply/divide unit
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Multiplication is a shift-add over 2*XLEN bits, division is restoring;
// both retire one bit per cycle, so a normal operation takes XLEN cycles in
// CALC followed by a one-cycle DONE. Divide-by-zero and signed overflow
// (most-negative / -1) bypass the iteration and complete in one cycle.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - muldiv_unit_if.slave: start, flush, op, rs1, rs2 in;
//            busy, done, result out
//
// Optional feature macro:
//   MULDIV_FAST_MUL_EN - when defined, multiply ops compute the full product
//   combinationally at launch and complete in one cycle; divide unchanged.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Architectural state. hi/lo are shared between the two algorithms:
    // multiply keeps the running product {hi,lo} with the multiplier in lo,
    // divide keeps the partial remainder in hi and the dividend/quotient in lo.
    state_t          state_q,   state_d;
    logic [2:0]      op_q,      op_d;
    logic [CW-1:0]   count_q,   count_d;
    logic [XLEN-1:0] hi_q,      hi_d;
    logic [XLEN-1:0] lo_q,      lo_d;
    logic [XLEN-1:0] b_q,       b_d;
    logic            neg_q,     neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q,  result_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    // Launch-time operand decode
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            div_overflow;
    logic [XLEN-1:0] special_result;

    // One iteration of the active algorithm and the final result selection
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] step_prod;
    logic [2*XLEN-1:0] signed_prod;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   final_result;

    // Operand signedness follows func3: MULH and DIV/REM treat both operands
    // as signed, MULHSU only rs1. Magnitudes of the most-negative value wrap
    // to 2^(XLEN-1), which is exactly right when read as unsigned.
    always_comb begin
        a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                   (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                   (bus.op == OP_REM);
        a_neg    = a_signed && bus.rs1[XLEN-1];
        b_neg    = b_signed && bus.rs2[XLEN-1];
        a_mag    = a_neg ? -bus.rs1 : bus.rs1;
        b_mag    = b_neg ? -bus.rs2 : bus.rs2;

        div_by_zero  = bus.op[2] && (bus.rs2 == '0);
        div_overflow = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                       (bus.rs1 == MIN_SIGNED) && (bus.rs2 == ALL_ONES);

        // REM/REMU keep the dividend on divide-by-zero; overflow yields the
        // dividend as quotient and zero remainder.
        special_result = '0;
        if (div_by_zero) begin
            special_result = bus.op[1] ? bus.rs1 : ALL_ONES;
        end else if (div_overflow) begin
            special_result = bus.op[1] ? '0 : MIN_SIGNED;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_result;

    // Single-cycle product straight from the launch operands.
    always_comb begin
        fast_mag    = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        fast_prod   = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
        fast_result = (bus.op == OP_MUL) ? fast_prod[XLEN-1:0]
                                         : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // One algorithm step. Multiply adds the multiplicand into the high half
    // when the current multiplier bit is set, then shifts the whole product
    // right with the carry. Divide shifts the next dividend bit into the
    // partial remainder and keeps the subtraction only if it did not borrow.
    // The final-step values feed the result directly so it lands on the same
    // edge that leaves CALC.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};

        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        step_prod   = {step_hi, step_lo};
        signed_prod = neg_q ? -step_prod : step_prod;
        quotient    = neg_q ? -step_lo : step_lo;
        remainder   = neg_rem_q ? -step_hi : step_hi;

        case (op_q)
            OP_MUL:                        final_result = signed_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_result = signed_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_result = quotient;
            OP_REM, OP_REMU:               final_result = remainder;
            default:                       final_result = quotient;
        endcase
    end

    // Next-state logic. Flush overrides everything, including a start in the
    // same cycle and a completion on the last iteration, and never touches
    // the result register.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (bus.start) begin
                        op_d      = bus.op;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        count_d   = CW'(XLEN - 1);
                        hi_d      = '0;
                        if (bus.op[2]) begin
                            lo_d = a_mag;
                            b_d  = b_mag;
                        end else begin
                            lo_d = b_mag;
                            b_d  = a_mag;
                        end

                        if (div_by_zero || div_overflow) begin
                            state_d  = DONE;
                            result_d = special_result;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!bus.op[2]) begin
                            state_d  = DONE;
                            result_d = fast_result;
`endif
                        end else begin
                            state_d = CALC;
                        end
                    end
                end

                CALC: begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    count_d = count_q - 1'b1;
                    if (count_q == '0) begin
                        state_d  = DONE;
                        result_d = final_result;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; busy/done are registered copies of the
    // state decode so the hazard unit sees glitch-free flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
//
// Cycle numbering: the rising edge that samples start is edge 0; cycle k is
// the period after edge k-1. Inputs are driven and outputs sampled on the
// falling edge, so a value seen at a negedge belongs to that cycle.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 32;
`endif

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   done_cyc;
    int   busy_cnt;
    int   done_seen;
    int   busy_seen;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one operation for a single cycle; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // From the negedge of cycle 1, find the done cycle and count busy cycles.
    // A missing done within the budget reports cycle -1.
    task automatic waitDone(output int cyc, output int busy_count);
        bit found;
        found      = 1'b0;
        cyc        = 1;
        busy_count = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.busy) busy_count++;
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!found) cyc = -1;
    endtask

    // Watch n cycles and count how many had done or busy high.
    task automatic watchQuiet(input int n, output int dones, output int busys);
        dones = 0;
        busys = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busys++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected, input int lat, input int busy_exp);
        applyStimulus(op, a, b);
        waitDone(done_cyc, busy_cnt);
        checkOutput({tag, "_result"}, bus.result, expected);
        checkOutput({tag, "_latency"}, 32'(done_cyc), 32'(lat));
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
    endtask

    // Directed sequence: reset, arithmetic, special cases, flush, back-to-back, reset abort.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 3'b000;
        bus.rs1      = '0;
        bus.rs2      = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;

        runOp("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, MUL_BUSY);
        runOp("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, MUL_BUSY);
        runOp("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, MUL_BUSY);
        runOp("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY);

        runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
        runOp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
        runOp("divu_m7_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 32);
        runOp("remu_m7_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33, 32);

        runOp("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        runOp("rem_by_zero", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
        runOp("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        runOp("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Distinct prior result so an illegal write during flush is visible
        runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 32);

        // Flush sampled at edge 10 of a DIVU
        applyStimulus(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        checkOutput("flush_busy_before", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush_busy_after", {31'b0, bus.busy}, 32'd0);
        checkOutput("flush_result_kept", bus.result, 32'd14);
        watchQuiet(40, done_seen, busy_seen);
        checkOutput("flush_no_done", 32'(done_seen), 32'd0);

        // Back-to-back: start asserted during the DONE cycle
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        waitDone(done_cyc, busy_cnt);
        checkOutput("b2b_first_result", bus.result, 32'd14);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.rs1   = 32'hFFFF_FFF9;
        bus.rs2   = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("b2b_done_dropped", {31'b0, bus.done}, 32'd0);
        checkOutput("b2b_busy_rose", {31'b0, bus.busy}, 32'd1);
        waitDone(done_cyc, busy_cnt);
        checkOutput("b2b_second_latency", 32'(done_cyc), 32'd33);
        checkOutput("b2b_second_result", bus.result, 32'hFFFF_FFFD);

        // Flush and start together: nothing launches
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd9;
        bus.rs2   = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checkOutput("flush_start_busy", {31'b0, bus.busy}, 32'd0);
        watchQuiet(40, done_seen, busy_seen);
        checkOutput("flush_start_no_done", 32'(done_seen), 32'd0);
        checkOutput("flush_start_no_busy", 32'(busy_seen), 32'd0);
        checkOutput("flush_start_result", bus.result, 32'hFFFF_FFFD);

        // Asynchronous reset in cycle 15 of a MUL
        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst_mid_done", {31'b0, bus.done}, 32'd0);
        checkOutput("rst_mid_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watchQuiet(40, done_seen, busy_seen);
        checkOutput("rst_release_no_done", 32'(done_seen), 32'd0);
        checkOutput("rst_release_no_busy", 32'(busy_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
